nr_divider: RTL and testbench

//  Iterative radix-2 non-restoring integer divider, the inverse companion to the Booth/Wallace multiplier.

---
 rtl/nr_divider_if.sv | 27 ++
 rtl/nr_divider.sv | 119 +++++++++++
 tb/tb_nr_divider.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/nr_divider_if.sv
// Operand/result handshake bundle for the non-restoring divider.
`timescale 1ns/1ps

interface nr_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output in_valid, x, y, signed_mode, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, x, y, signed_mode, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/nr_divider.sv
// Iterative radix-2 non-restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour signed_mode; otherwise all operands are unsigned.
`timescale 1ns/1ps

module nr_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RST,
  nr_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic             sx;
  logic             sy;
  logic [CNT_W-1:0] cnt;

  logic             in_sx;
  logic             in_sy;
  logic [WIDTH-1:0] mag_x;
  logic [WIDTH-1:0] mag_y;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH:0]   p_fix;

`ifdef DIV_SIGNED_EN
  assign in_sx = bus.signed_mode & bus.x[WIDTH-1];
  assign in_sy = bus.signed_mode & bus.y[WIDTH-1];
  assign mag_x = in_sx ? (~bus.x + WIDTH'(1)) : bus.x;
  assign mag_y = in_sy ? (~bus.y + WIDTH'(1)) : bus.y;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign in_sx = 1'b0;
  assign in_sy = 1'b0;
  assign mag_x = bus.x;
  assign mag_y = bus.y;
`endif

  // One non-restoring step: shift in next dividend bit, then add or subtract D by sign of P.
  always_comb begin
    p_sh  = {p[WIDTH-1:0], a[WIDTH-1]};
    p_nx  = p[WIDTH] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
    p_fix = p[WIDTH] ? (p + {1'b0, d}) : p;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      p               <= '0;
      a               <= '0;
      d               <= '0;
      sx              <= 1'b0;
      sy              <= 1'b0;
      cnt             <= '0;
      bus.q           <= '0;
      bus.r           <= '0;
      bus.div_by_zero <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.in_ready    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            if (bus.y == '0) begin
              bus.q           <= '1;
              bus.r           <= bus.x;
              bus.div_by_zero <= 1'b1;
              bus.out_valid   <= 1'b1;
              state           <= DONE;
            end else begin
              p     <= '0;
              a     <= mag_x;
              d     <= mag_y;
              sx    <= in_sx;
              sy    <= in_sy;
              cnt   <= CNT_W'(WIDTH);
              state <= CALC;
            end
          end
        end
        // Final counter==0 cycle restores a negative partial remainder.
        CALC: begin
          if (cnt != '0) begin
            p   <= p_nx;
            a   <= {a[WIDTH-2:0], ~p_nx[WIDTH]};
            cnt <= cnt - CNT_W'(1);
          end else begin
            p     <= p_fix;
            state <= FIX;
          end
        end
        // Truncating division: remainder follows the dividend sign.
        FIX: begin
          bus.q           <= (sx ^ sy) ? (~a + WIDTH'(1)) : a;
          bus.r           <= sx ? (~p[WIDTH-1:0] + WIDTH'(1)) : p[WIDTH-1:0];
          bus.div_by_zero <= 1'b0;
          bus.out_valid   <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nr_divider.sv
// Directed vector bench for nr_divider (WIDTH=32), plus backpressure and reset-abort sequences.
`timescale 1ns/1ps

module tb_nr_divider;
  localparam int unsigned W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sm;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    int           elat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  nr_divider_if #(.WIDTH(W)) bus ();

  nr_divider #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, measure cycles from accept edge to out_valid, then retire it.
  task automatic run_op(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic smi,
                        output logic [W-1:0] qo, output logic [W-1:0] ro,
                        output logic dbzo, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    bus.x = xi; bus.y = yi; bus.signed_mode = smi; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    qo = bus.q; ro = bus.r; dbzo = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t         vecs[13];
  logic [W-1:0] gq, gr;
  logic         gdbz;
  int           glat;
  bit           seen;

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.signed_mode = 1'b0; bus.out_ready = 1'b0;

    vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1, SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                 SGN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 34};
    vecs[2]  = '{32'd7, 32'hFFFF_FFFE, 1'b1, SGN ? 32'hFFFF_FFFD : 32'd0,
                 SGN ? 32'd1 : 32'd7, 1'b0, 34};
    vecs[3]  = '{32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1};
    vecs[4]  = '{32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, SGN ? 32'h8000_0000 : 32'd0,
                 SGN ? 32'd0 : 32'h8000_0000, 1'b0, 34};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 34};
    vecs[7]  = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34};
    vecs[8]  = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34};
    vecs[9]  = '{32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, 34};
    vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, SGN ? 32'd14 : 32'd0,
                 SGN ? 32'hFFFF_FFFE : 32'hFFFF_FF9C, 1'b0, 34};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34};
    vecs[12] = '{32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 34};

    repeat (2) @(posedge clk);
    #1;
    check("rst_q", bus.q, '0);
    check("rst_r", bus.r, '0);
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_dbz", W'(bus.div_by_zero), '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", W'(bus.in_ready), W'(1));

    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].sm, gq, gr, gdbz, glat);
      check($sformatf("v%0d_q", i), gq, vecs[i].eq);
      check($sformatf("v%0d_r", i), gr, vecs[i].er);
      check($sformatf("v%0d_dbz", i), W'(gdbz), W'(vecs[i].edbz));
      check($sformatf("v%0d_lat", i), W'(glat), W'(vecs[i].elat));
      check($sformatf("v%0d_in_ready", i), W'(bus.in_ready), W'(1));
    end

    // Reset mid-CALC discards the operation and clears the previous result.
    bus.x = 32'd100; bus.y = 32'd7; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(bus.out_valid), '0);
    check("abort_q", bus.q, '0);
    check("abort_r", bus.r, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", W'(bus.in_ready), W'(1));
    run_op(32'd9, 32'd3, 1'b0, gq, gr, gdbz, glat);
    check("after_abort_q", gq, 32'd3);
    check("after_abort_r", gr, 32'd0);

    // Backpressure: result held with out_ready low; new operands ignored meanwhile.
    bus.x = 32'd100; bus.y = 32'd7; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_seen", W'(seen), W'(1));
    bus.x = 32'd5; bus.y = 32'd1; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_q", bus.q, 32'd14);
      check("bp_r", bus.r, 32'd2);
      check("bp_in_ready", W'(bus.in_ready), '0);
      check("bp_out_valid", W'(bus.out_valid), W'(1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("retire_in_ready", W'(bus.in_ready), W'(1));
    check("retire_out_valid", W'(bus.out_valid), '0);
    run_op(32'd9, 32'd3, 1'b0, gq, gr, gdbz, glat);
    check("post_bp_q", gq, 32'd3);
    check("post_bp_r", gr, 32'd0);
    check("post_bp_lat", W'(glat), W'(34));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
